// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the multicycle MIPS control path
package mips_ctrl_pkg;

  // Sequencer states; codes are visible on the debug port
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  // Instruction classes produced by mc_decode
  typedef enum logic [3:0] {
    IC_RTYPE   = 4'd0,
    IC_ORI     = 4'd1,
    IC_LUI     = 4'd2,
    IC_LW      = 4'd3,
    IC_SW      = 4'd4,
    IC_BEQ     = 4'd5,
    IC_J       = 4'd6,
    IC_JAL     = 4'd7,
    IC_ILLEGAL = 4'd8
  } iclass_e;

  // Opcodes (Instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type function codes (Instruction[5:0])
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  // Next-PC select
  localparam logic [1:0] NPC_PC4    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;

  // Register-file write-data select
  localparam logic [1:0] WD_ALU  = 2'b00;
  localparam logic [1:0] WD_DMEM = 2'b01;
  localparam logic [1:0] WD_PC   = 2'b10;

  // Register-file destination select
  localparam logic [1:0] GPR_RD  = 2'b00;
  localparam logic [1:0] GPR_RT  = 2'b01;
  localparam logic [1:0] GPR_R31 = 2'b10;

  // Immediate extender mode
  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  // ALU operation
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_SLT = 2'b11;

  // Extender mode implied by an instruction class
  function automatic logic [1:0] ext_op_of(input iclass_e c);
    case (c)
      IC_LW, IC_SW, IC_BEQ: ext_op_of = EXT_SIGN;
      IC_LUI:               ext_op_of = EXT_LUI;
      default:              ext_op_of = EXT_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - op/funct to instruction class and illegal flag
module mc_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output iclass_e    iclass,
  output logic [1:0] r_alu_op,
  output logic       illegal
);

  // Classify the instruction; R-type also yields its ALU operation
  always_comb begin
    iclass   = IC_ILLEGAL;
    r_alu_op = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: begin iclass = IC_RTYPE; r_alu_op = ALU_ADD; end
          FN_SUBU: begin iclass = IC_RTYPE; r_alu_op = ALU_SUB; end
          FN_OR:   begin iclass = IC_RTYPE; r_alu_op = ALU_OR;  end
          FN_SLT:  begin iclass = IC_RTYPE; r_alu_op = ALU_SLT; end
          default: iclass = IC_ILLEGAL;
        endcase
      end
      OP_ORI:  iclass = IC_ORI;
      OP_LUI:  iclass = IC_LUI;
      OP_LW:   iclass = IC_LW;
      OP_SW:   iclass = IC_SW;
      OP_BEQ:  iclass = IC_BEQ;
      OP_J:    iclass = IC_J;
      OP_JAL:  iclass = IC_JAL;
      default: iclass = IC_ILLEGAL;
    endcase
  end

  assign illegal = (iclass == IC_ILLEGAL);

endmodule

// File: rtl/mc_sequencer.sv
// rtl/mc_sequencer.sv - five-state multicycle control FSM with retire counter
module mc_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             dm_ready,
  output logic             PCWr,
  output logic             IRWr,
  output logic             RFWr,
  output logic             DMWr,
  output logic [1:0]       NPCOp,
  output logic [1:0]       WDSel,
  output logic [1:0]       GPRSel,
  output logic             Bsel,
  output logic [1:0]       EXTOp,
  output logic [1:0]       ALUOp,
  output logic [2:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] retire_cnt
);

  state_e     state_q;
  state_e     state_d;
  iclass_e    iclass;
  logic [1:0] r_alu_op;
  logic       dec_illegal;
  logic       retire;
  logic [1:0] alu_sel;
  logic       b_sel;
  logic [1:0] ext_sel;

  mc_decode u_decode (
    .op       (op),
    .funct    (funct),
    .iclass   (iclass),
    .r_alu_op (r_alu_op),
    .illegal  (dec_illegal)
  );

  assign state = state_q;

  // ALU-side controls per class; held unchanged from EXEC through WB
  always_comb begin
    alu_sel = ALU_ADD;
    b_sel   = 1'b0;
    ext_sel = ext_op_of(iclass);
    case (iclass)
      IC_RTYPE:     begin alu_sel = r_alu_op; b_sel = 1'b0; end
      IC_ORI:       begin alu_sel = ALU_OR;   b_sel = 1'b1; end
      IC_LUI:       begin alu_sel = ALU_OR;   b_sel = 1'b1; end
      IC_LW, IC_SW: begin alu_sel = ALU_ADD;  b_sel = 1'b1; end
      IC_BEQ:       begin alu_sel = ALU_SUB;  b_sel = 1'b0; end
      default:      begin alu_sel = ALU_ADD;  b_sel = 1'b0; end
    endcase
  end

  // Next state and datapath controls; everything forced low while in reset
  always_comb begin
    state_d = ST_FETCH;
    PCWr    = 1'b0;
    IRWr    = 1'b0;
    RFWr    = 1'b0;
    DMWr    = 1'b0;
    NPCOp   = NPC_PC4;
    WDSel   = WD_ALU;
    GPRSel  = GPR_RD;
    Bsel    = 1'b0;
    EXTOp   = EXT_ZERO;
    ALUOp   = ALU_ADD;
    illegal = 1'b0;
    retire  = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          IRWr    = 1'b1;
          PCWr    = 1'b1;
          NPCOp   = NPC_PC4;
          state_d = ST_DECODE;
        end
        ST_DECODE: begin
          EXTOp = ext_sel;
          case (iclass)
            IC_J: begin
              PCWr    = 1'b1;
              NPCOp   = NPC_JUMP;
              retire  = 1'b1;
              state_d = ST_FETCH;
            end
            IC_JAL: begin
              // PC already holds PC+4 from FETCH, so it is the link value
              PCWr    = 1'b1;
              NPCOp   = NPC_JUMP;
              RFWr    = 1'b1;
              GPRSel  = GPR_R31;
              WDSel   = WD_PC;
              retire  = 1'b1;
              state_d = ST_FETCH;
            end
            IC_ILLEGAL: begin
              illegal = dec_illegal;
              state_d = ST_FETCH;
            end
            default: state_d = ST_EXEC;
          endcase
        end
        ST_EXEC: begin
          ALUOp = alu_sel;
          Bsel  = b_sel;
          EXTOp = ext_sel;
          case (iclass)
            IC_BEQ: begin
              // Not-taken beq still retires; PC keeps the FETCH increment
              NPCOp   = NPC_BRANCH;
              PCWr    = zero;
              retire  = 1'b1;
              state_d = ST_FETCH;
            end
            IC_LW, IC_SW:             state_d = ST_MEM;
            IC_RTYPE, IC_ORI, IC_LUI: state_d = ST_WB;
            default:                  state_d = ST_FETCH;
          endcase
        end
        ST_MEM: begin
          ALUOp = alu_sel;
          Bsel  = b_sel;
          EXTOp = ext_sel;
          case (iclass)
            IC_SW: begin
              DMWr = 1'b1;
              if (dm_ready) begin
                retire  = 1'b1;
                state_d = ST_FETCH;
              end else begin
                state_d = ST_MEM;
              end
            end
            IC_LW:   state_d = dm_ready ? ST_WB : ST_MEM;
            default: state_d = ST_FETCH;
          endcase
        end
        ST_WB: begin
          ALUOp   = alu_sel;
          Bsel    = b_sel;
          EXTOp   = ext_sel;
          RFWr    = 1'b1;
          GPRSel  = (iclass == IC_RTYPE) ? GPR_RD : GPR_RT;
          WDSel   = (iclass == IC_LW) ? WD_DMEM : WD_ALU;
          retire  = 1'b1;
          state_d = ST_FETCH;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  // State register and retired-instruction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      retire_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        retire_cnt <= retire_cnt + CNT_W'(1);
      end
    end
  end

endmodule
